// File: rtl/bus_transfer_ctrl_pkg.sv
// Shared definitions for the bus transfer sequencer and the register bank it drives.
package bus_transfer_ctrl_pkg;

  // Sequencer phases: drive the source, strobe the destination load, then report completion
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    LATCH   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Default bank geometry, shared with the register bank
  localparam int DEFAULT_NUM_REGS = 8;
  localparam int DEFAULT_DATA_W   = 32;

endpackage

// File: rtl/bus_transfer_ctrl_onehot_decoder.sv
// Index-to-one-hot decoder with an enable. Indices outside the bank decode to all zeros.
module onehot_decoder #(
  parameter int SEL_W    = 3,
  parameter int NUM_REGS = 8
) (
  input  logic [SEL_W-1:0]    sel,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  // Raise exactly the line whose index matches sel, and only while enabled
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (sel == SEL_W'(i))) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_transfer_ctrl.sv
// Register-to-register transfer sequencer: drives the source onto the shared bus,
// strobes the destination load one cycle later, captures the moved word, and
// rejects out-of-range or self-transfers with a one-cycle error pulse.
module bus_transfer_ctrl
  import bus_transfer_ctrl_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int SEL_W    = 3,
  parameter int DATA_W   = DEFAULT_DATA_W
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SEL_W-1:0]    src_sel,
  input  logic [SEL_W-1:0]    dst_sel,
  input  logic [DATA_W-1:0]   bus,
  output logic [NUM_REGS-1:0] out_en,
  output logic [NUM_REGS-1:0] in_en,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [DATA_W-1:0]   last_word
);

  // Bank size widened by one bit so any select value can be compared against it
  localparam logic [SEL_W:0] NUM_REGS_W = (SEL_W+1)'(NUM_REGS);

  state_t               state;
  state_t               state_next;
  logic [SEL_W-1:0]     src_q;
  logic [SEL_W-1:0]     dst_q;
  logic [SEL_W-1:0]     src_next;
  logic [SEL_W-1:0]     dst_next;
  logic                 legal;
  logic                 drive_src_next;
  logic                 drive_dst_next;
  logic                 busy_next;
  logic                 done_next;
  logic                 err_next;
  logic [NUM_REGS-1:0]  out_en_next;
  logic [NUM_REGS-1:0]  in_en_next;

  // The controller only listens for requests while idle
  assign req_ready = (state == IDLE);

  // A request must name two distinct registers that exist on the bus
  assign legal = ({1'b0, src_sel} < NUM_REGS_W) &&
                 ({1'b0, dst_sel} < NUM_REGS_W) &&
                 (src_sel != dst_sel);

  // State and sampled selects; selects are frozen from acceptance until the next one
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      src_q <= '0;
      dst_q <= '0;
    end else begin
      state <= state_next;
      src_q <= src_next;
      dst_q <= dst_next;
    end
  end

  // Next state plus the next-cycle values of every registered output
  always_comb begin
    state_next     = state;
    src_next       = src_q;
    dst_next       = dst_q;
    err_next       = 1'b0;
    busy_next      = 1'b0;
    done_next      = 1'b0;
    drive_src_next = 1'b0;
    drive_dst_next = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (legal) begin
            state_next = DRIVE;
            src_next   = src_sel;
            dst_next   = dst_sel;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      DRIVE:   state_next = LATCH;
      LATCH:   state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next      = (state_next != IDLE);
    done_next      = (state_next == RELEASE);
    drive_src_next = (state_next == DRIVE) || (state_next == LATCH);
    drive_dst_next = (state_next == LATCH);
  end

  onehot_decoder #(
    .SEL_W    (SEL_W),
    .NUM_REGS (NUM_REGS)
  ) u_out_dec (
    .sel    (src_next),
    .en     (drive_src_next),
    .onehot (out_en_next)
  );

  onehot_decoder #(
    .SEL_W    (SEL_W),
    .NUM_REGS (NUM_REGS)
  ) u_in_dec (
    .sel    (dst_next),
    .en     (drive_dst_next),
    .onehot (in_en_next)
  );

  // Registered strobes and status so the bank never sees a combinational path from req_valid
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      out_en    <= '0;
      in_en     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      last_word <= '0;
    end else begin
      out_en <= out_en_next;
      in_en  <= in_en_next;
      busy   <= busy_next;
      done   <= done_next;
      err    <= err_next;
      if (state == LATCH) begin
        last_word <= bus;
      end
    end
  end

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Scoreboard bench for bus_transfer_ctrl with a small register bank on the bus.
module tb_bus_transfer_ctrl;

  localparam int NUM_REGS = 8;
  localparam int SEL_W    = 4;
  localparam int DATA_W   = 32;

  logic                clk = 1'b0;
  logic                clr;
  logic                req_valid;
  logic                req_ready;
  logic [SEL_W-1:0]    src_sel;
  logic [SEL_W-1:0]    dst_sel;
  logic [DATA_W-1:0]   bus;
  logic [NUM_REGS-1:0] out_en;
  logic [NUM_REGS-1:0] in_en;
  logic                busy;
  logic                done;
  logic                err;
  logic [DATA_W-1:0]   last_word;

  typedef struct {
    bit          legal;
    int          src;
    int          dst;
    logic [31:0] data;
    logic [31:0] old;
    int          acc;
  } txn_t;

  txn_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          model_free = 0;
  logic [31:0] model_last = '0;
  logic [31:0] bank_model [NUM_REGS];
  logic [31:0] init_val [NUM_REGS];
  logic [31:0] bank [NUM_REGS];
  logic        bank_load;
  bit          mon_en = 1'b0;

  bus_transfer_ctrl #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W),
    .DATA_W   (DATA_W)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .src_sel   (src_sel),
    .dst_sel   (dst_sel),
    .bus       (bus),
    .out_en    (out_en),
    .in_en     (in_en),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .last_word (last_word)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register bank: the enabled register drives the bus, the strobed one loads it
  always_comb begin
    bus = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (out_en[i]) bus = bus | bank[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bank_load) bank[i] <= init_val[i];
      else if (in_en[i]) bank[i] <= bus;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Present a request at a falling edge, hold it until the model says it is taken, then record the outcome
  task automatic applyStimulus(input int s, input int d);
    txn_t t;
    req_valid = 1'b1;
    src_sel   = SEL_W'(s);
    dst_sel   = SEL_W'(d);
    while (cyc < model_free) begin
      checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    t.legal = (s < NUM_REGS) && (d < NUM_REGS) && (s != d);
    t.src   = s;
    t.dst   = d;
    t.acc   = cyc;
    t.data  = t.legal ? bank_model[s] : 32'd0;
    t.old   = t.legal ? bank_model[d] : 32'd0;
    if (t.legal) bank_model[d] = t.data;
    q.push_back(t);
    model_free = cyc + (t.legal ? 4 : 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: expected strobes come from the oldest outstanding request; done/err retire it
  always @(negedge clk) begin
    if (mon_en) begin
      automatic logic [7:0]  e_out = '0;
      automatic logic [7:0]  e_in = '0;
      automatic logic        e_busy = 1'b0;
      automatic logic        e_done = 1'b0;
      automatic logic        e_err = 1'b0;
      automatic logic [31:0] e_last = model_last;
      automatic int          d = 0;
      automatic txn_t        h;
      if (q.size() > 0) begin
        h = q[0];
        d = cyc - h.acc;
        if (h.legal) begin
          if (d == 1) begin e_out = 8'b1 << h.src; e_busy = 1'b1; end
          if (d == 2) begin e_out = 8'b1 << h.src; e_in = 8'b1 << h.dst; e_busy = 1'b1; end
          if (d == 3) begin e_done = 1'b1; e_busy = 1'b1; e_last = h.data; end
        end else if (d == 1) begin
          e_err = 1'b1;
        end
      end
      checkOutput("out_en", 32'(out_en), 32'(e_out));
      checkOutput("in_en", 32'(in_en), 32'(e_in));
      checkOutput("busy", 32'(busy), 32'(e_busy));
      checkOutput("done", 32'(done), 32'(e_done));
      checkOutput("err", 32'(err), 32'(e_err));
      checkOutput("last_word", last_word, e_last);
      if (done || err) begin
        if (q.size() == 0) begin
          checkOutput("unexpected_completion", 32'(q.size()), 32'd1);
        end else begin
          h = q.pop_front();
          d = cyc - h.acc;
          checkOutput("completion_kind", 32'(done), 32'(h.legal));
          checkOutput("completion_latency", 32'(d), h.legal ? 32'd3 : 32'd1);
          if (h.legal) model_last = h.data;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    automatic int s;
    automatic int d;
    automatic txn_t t;
    for (int i = 0; i < NUM_REGS; i++) init_val[i] = $urandom;
    init_val[2] = 32'd24;
    for (int i = 0; i < NUM_REGS; i++) bank_model[i] = init_val[i];
    bank_load = 1'b1;
    clr       = 1'b0;
    req_valid = 1'b1;
    src_sel   = 4'd0;
    dst_sel   = 4'd1;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_en", 32'(out_en), 32'd0);
    checkOutput("reset_in_en", 32'(in_en), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_last_word", last_word, 32'd0);
    req_valid  = 1'b0;
    clr        = 1'b1;
    bank_load  = 1'b0;
    #1;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    model_free = cyc;
    mon_en     = 1'b1;

    applyStimulus(2, 5);
    idle(3);
    checkOutput("reg5_loaded", bank[5], 32'd24);

    applyStimulus(3, 3);
    applyStimulus(2, 9);
    idle(1);

    applyStimulus(1, 0);
    applyStimulus(0, 7);

    applyStimulus(3, 1);
    applyStimulus(6, 2);
    idle(4);

    applyStimulus(4, 6);
    mon_en = 1'b0;
    #1;
    clr = 1'b0;
    #1;
    checkOutput("abort_out_en", 32'(out_en), 32'd0);
    checkOutput("abort_in_en", 32'(in_en), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_last_word", last_word, 32'd0);
    while (q.size() > 0) begin
      t = q.pop_back();
      if (t.legal) bank_model[t.dst] = t.old;
    end
    model_last = '0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    checkOutput("reg6_kept", bank[6], bank_model[6]);
    model_free = cyc;
    mon_en     = 1'b1;
    applyStimulus(4, 6);
    idle(4);
    checkOutput("reg6_after_retry", bank[6], bank_model[6]);

    for (int n = 0; n < 60; n++) begin
      s = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      applyStimulus(s, d);
    end

    idle(1);
    while (cyc < model_free + 2) @(negedge clk);
    checkOutput("queue_drained", 32'(q.size()), 32'd0);
    for (int i = 0; i < NUM_REGS; i++) begin
      checkOutput($sformatf("bank_reg%0d", i), bank[i], bank_model[i]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
